if_layer_weight_loader: RTL and testbench

Initiator for the IF layer's weight-memory port: it accepts a valid/ready stream of weight words and writes them in neuron-major order into every neuron's weight memory. It optionally reads the whole address space back and compares an additive checksum of the read words against the written words. It holds the layer in reset for the whole load. It sits between the host/config fabric and the layer's `mem_addr/mem_din/mem_wen/mem_dout` port.

---
 rtl/if_layer_weight_loader_if.sv | 25 ++
 rtl/if_layer_weight_loader.sv | 156 +++++++++++++++
 tb/tb_if_layer_weight_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_layer_weight_loader_if.sv
// Bundles the weight stream (valid/ready) and the layer weight-memory port
// used by if_layer_weight_loader. The master view is the loader; the slave
// view is the environment (host stream source plus the weight memory).
interface if_layer_weight_loader_if #(
    parameter int WEIGHT_SIZE       = 32,
    parameter int NEURON_ADDR_WIDTH = 28
);
    logic                         s_valid;
    logic                         s_ready;
    logic [WEIGHT_SIZE-1:0]       s_data;
    logic [NEURON_ADDR_WIDTH-1:0] mem_addr;
    logic [WEIGHT_SIZE-1:0]       mem_din;
    logic                         mem_wen;
    logic [WEIGHT_SIZE-1:0]       mem_dout;

    modport master (
        input  s_valid, s_data, mem_dout,
        output s_ready, mem_addr, mem_din, mem_wen
    );

    modport slave (
        output s_valid, s_data, mem_dout,
        input  s_ready, mem_addr, mem_din, mem_wen
    );
endinterface

// File: rtl/if_layer_weight_loader.sv
// Weight loader for the IF layer: writes a stream of weight words into every
// neuron's weight memory in neuron-major order, optionally reads the whole
// address space back and compares additive checksums, and holds the layer in
// reset while the load is in progress.
module if_layer_weight_loader #(
    parameter int WEIGHT_SIZE       = 32,
    parameter int NUM_INPUTS        = 4,
    parameter int NUM_NEURONS       = 1,
    parameter int NEURON_ADDR_WIDTH = 28,
    parameter int WEIGHT_ADDR_WIDTH = 10,
    parameter int VERIFY            = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    if_layer_weight_loader_if.master bus,
    output logic                   layer_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [WEIGHT_SIZE-1:0] checksum
);
    localparam int NIDX_W = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;
    localparam logic [NIDX_W-1:0]            N_LAST = NIDX_W'(NUM_NEURONS - 1);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] W_LAST = WEIGHT_ADDR_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_CHECK
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [NIDX_W-1:0]          n;
    logic [WEIGHT_ADDR_WIDTH-1:0] w;
    logic [WEIGHT_SIZE-1:0]     sum_w;
    logic [WEIGHT_SIZE-1:0]     sum_r;
    logic                       rd_pend;
    logic                       accept;
    logic                       step;
    logic                       at_last;

    // A word is consumed only in WRITE; the address walks on every accept
    // and on every READ cycle.
    assign accept   = (state == S_WRITE) && bus.s_valid;
    assign step     = accept || (state == S_READ);
    assign at_last  = (n == N_LAST) && (w == W_LAST);
    assign checksum = sum_w;

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WRITE;
            S_WRITE: begin
                if (accept && at_last) begin
                    state_nxt = (VERIFY != 0) ? S_READ : S_IDLE;
                end
            end
            S_READ:  if (at_last) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Port outputs; everything falls back to zero outside the active states.
    always_comb begin
        bus.s_ready  = 1'b0;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        busy         = (state != S_IDLE);
        layer_hold   = (state != S_IDLE);
        case (state)
            S_WRITE: begin
                bus.s_ready  = 1'b1;
                bus.mem_wen  = bus.s_valid;
                bus.mem_addr = {n, w};
                bus.mem_din  = bus.s_data;
            end
            S_READ: begin
                bus.mem_addr = {n, w};
            end
            default: ;
        endcase
    end

    // Address walk, checksums and sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n       <= '0;
            w       <= '0;
            sum_w   <= '0;
            sum_r   <= '0;
            rd_pend <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            // Read data arrives one cycle after its address was issued.
            rd_pend <= (state == S_READ);
            if (rd_pend) begin
                sum_r <= sum_r + bus.mem_dout;
            end

            if (state == S_IDLE && start) begin
                n     <= '0;
                w     <= '0;
                sum_w <= '0;
                sum_r <= '0;
                done  <= 1'b0;
                error <= 1'b0;
            end

            if (accept) begin
                sum_w <= sum_w + bus.s_data;
                if (at_last && VERIFY == 0) begin
                    done <= 1'b1;
                end
            end

            if (step) begin
                if (at_last) begin
                    n <= '0;
                    w <= '0;
                end else if (w == W_LAST) begin
                    w <= '0;
                    n <= n + 1'b1;
                end else begin
                    w <= w + 1'b1;
                end
            end

            if (state == S_CHECK) begin
                error <= (sum_r != sum_w);
                done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_if_layer_weight_loader.sv
// Self-checking bench for if_layer_weight_loader: two instances (readback on
// and off) on 2 neurons x 4 weights, each with an ideal synchronous memory.
// Expected writes come from a neuron-major address plan pushed into a
// scoreboard queue; a negedge monitor pops and compares every write beat.
module tb_if_layer_weight_loader;
    localparam int WS  = 32;
    localparam int NI  = 4;
    localparam int NN  = 2;
    localparam int NAW = 28;
    localparam int WAW = 10;
    localparam int N   = NI * NN;

    typedef struct {
        logic [NAW-1:0] addr;
        logic [WS-1:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic hold_a, busy_a, done_a, err_a;
    logic hold_b, busy_b, done_b, err_b;
    logic [WS-1:0] cks_a, cks_b;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  rise_a = 0;
    int  rise_b = 0;
    int  nonwrite_busy_b = 0;
    logic prev_done_a = 1'b0;
    logic prev_done_b = 1'b0;
    bit  corrupt_a = 1'b0;

    wr_t exp_a[$];
    wr_t exp_b[$];
    logic [WS-1:0] words [N];
    logic [WS-1:0] mem_a [0:2047];
    logic [WS-1:0] mem_b [0:2047];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    if_layer_weight_loader_if #(.WEIGHT_SIZE(WS), .NEURON_ADDR_WIDTH(NAW)) bus_a ();
    if_layer_weight_loader_if #(.WEIGHT_SIZE(WS), .NEURON_ADDR_WIDTH(NAW)) bus_b ();

    if_layer_weight_loader #(
        .WEIGHT_SIZE(WS), .NUM_INPUTS(NI), .NUM_NEURONS(NN),
        .NEURON_ADDR_WIDTH(NAW), .WEIGHT_ADDR_WIDTH(WAW), .VERIFY(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(bus_a.master),
        .layer_hold(hold_a), .busy(busy_a), .done(done_a), .error(err_a), .checksum(cks_a)
    );

    if_layer_weight_loader #(
        .WEIGHT_SIZE(WS), .NUM_INPUTS(NI), .NUM_NEURONS(NN),
        .NEURON_ADDR_WIDTH(NAW), .WEIGHT_ADDR_WIDTH(WAW), .VERIFY(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(bus_b.master),
        .layer_hold(hold_b), .busy(busy_b), .done(done_b), .error(err_b), .checksum(cks_b)
    );

    // Ideal synchronous-read memories; A can flip bit 0 of the word read at 1025.
    always @(posedge clk) begin
        if (bus_a.mem_wen) mem_a[bus_a.mem_addr[10:0]] <= bus_a.mem_din;
        bus_a.mem_dout <= mem_a[bus_a.mem_addr[10:0]]
                          ^ {31'b0, corrupt_a && (bus_a.mem_addr == 28'd1025)};
        if (bus_b.mem_wen) mem_b[bus_b.mem_addr[10:0]] <= bus_b.mem_din;
        bus_b.mem_dout <= mem_b[bus_b.mem_addr[10:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_port(input int sel, input logic wen, input logic vld, input logic rdy_i,
                            input logic [NAW-1:0] addr, input logic [WS-1:0] din);
        wr_t e;
        check($sformatf("dut%0d_wen_rule", sel), {63'b0, wen}, {63'b0, vld & rdy_i});
        if (wen === 1'b1) begin
            if ((sel == 0 ? exp_a.size() : exp_b.size()) == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut%0d_unexpected_write: addr %0h data %0h, no write expected",
                         sel, addr, din);
            end else begin
                e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
                check($sformatf("dut%0d_wr_addr", sel), 64'(addr), 64'(e.addr));
                check($sformatf("dut%0d_wr_data", sel), 64'(din), 64'(e.data));
            end
        end
    endtask

    // Monitor: scoreboard on write beats, done-edge counting, read-phase watch.
    always @(negedge clk) begin
        if (rst) begin
            mon_port(0, bus_a.mem_wen, bus_a.s_valid, bus_a.s_ready, bus_a.mem_addr, bus_a.mem_din);
            mon_port(1, bus_b.mem_wen, bus_b.s_valid, bus_b.s_ready, bus_b.mem_addr, bus_b.mem_din);
            if (done_a && !prev_done_a) rise_a++;
            if (done_b && !prev_done_b) rise_b++;
            if (busy_b && !bus_b.s_ready) nonwrite_busy_b++;
        end
        prev_done_a = done_a;
        prev_done_b = done_b;
    end

    task automatic drive(input int sel, input logic st, input logic v, input logic [WS-1:0] d);
        if (sel == 0) begin
            start_a = st; bus_a.s_valid = v; bus_a.s_data = d;
        end else begin
            start_b = st; bus_b.s_valid = v; bus_b.s_data = d;
        end
    endtask

    function automatic logic rdy_of(int sel);  return sel == 0 ? bus_a.s_ready : bus_b.s_ready; endfunction
    function automatic logic busy_of(int sel); return sel == 0 ? busy_a : busy_b; endfunction
    function automatic logic hold_of(int sel); return sel == 0 ? hold_a : hold_b; endfunction
    function automatic logic done_of(int sel); return sel == 0 ? done_a : done_b; endfunction
    function automatic logic err_of(int sel);  return sel == 0 ? err_a : err_b; endfunction
    function automatic logic [WS-1:0] cks_of(int sel); return sel == 0 ? cks_a : cks_b; endfunction

    // One load of words[]. mode: 0 back-to-back, 1 toggling valid, 2 random gaps.
    // abort_after > 0 resets the design right after that many accepts.
    task automatic run_load(input int sel, input int mode, input int abort_after,
                            input bit poke, input bit corrupt);
        logic [WS-1:0] exp_sum;
        wr_t e;
        int  idx, tick, last_cyc, budget, rises0, nonw0;
        bit  v, acc;
        exp_sum  = '0;
        last_cyc = cyc;
        for (int i = 0; i < N; i++) exp_sum += words[i];
        for (int nn = 0; nn < NN; nn++) begin
            for (int ww = 0; ww < NI; ww++) begin
                e.addr = NAW'(nn * (1 << WAW) + ww);
                e.data = words[nn * NI + ww];
                if (sel == 0) exp_a.push_back(e); else exp_b.push_back(e);
            end
        end
        if (sel == 0) corrupt_a = corrupt;
        rises0 = (sel == 0) ? rise_a : rise_b;
        nonw0  = nonwrite_busy_b;

        drive(sel, 1'b1, 1'b0, '0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, '0);
        check("start_busy", {63'b0, busy_of(sel)}, 64'd1);
        check("start_hold", {63'b0, hold_of(sel)}, 64'd1);
        check("start_ready", {63'b0, rdy_of(sel)}, 64'd1);
        check("start_clears_done", {63'b0, done_of(sel)}, 64'd0);
        check("start_clears_cks", 64'(cks_of(sel)), 64'd0);

        idx  = 0;
        tick = 0;
        while (idx < N) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (tick % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            drive(sel, poke && (tick % 3 == 1), v, words[idx]);
            acc = v && rdy_of(sel);
            @(posedge clk); #1;
            tick++;
            if (acc) begin
                idx++;
                last_cyc = cyc;
                if (abort_after != 0 && idx == abort_after) begin
                    drive(sel, 1'b0, 1'b1, words[idx]);
                    #2 rst = 1'b0;
                    #1;
                    check("rst_mem_wen", {63'b0, bus_a.mem_wen}, 64'd0);
                    check("rst_busy", {63'b0, busy_a}, 64'd0);
                    check("rst_ready", {63'b0, bus_a.s_ready}, 64'd0);
                    check("rst_hold", {63'b0, hold_a}, 64'd0);
                    check("rst_addr", 64'(bus_a.mem_addr), 64'd0);
                    check("rst_done", {63'b0, done_a}, 64'd0);
                    check("rst_cks", 64'(cks_a), 64'd0);
                    exp_a.delete();
                    corrupt_a = 1'b0;
                    drive(sel, 1'b0, 1'b0, '0);
                    @(negedge clk) rst = 1'b1;
                    @(posedge clk); #1;
                    return;
                end
            end
            if (tick > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL write_timeout: %0d of %0d words accepted", idx, N);
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, '0);

        budget = 0;
        while (!done_of(sel) && budget < 50) begin
            if (poke) drive(sel, (budget % 2 == 0), 1'b0, '0);
            @(posedge clk); #1;
            budget++;
        end
        drive(sel, 1'b0, 1'b0, '0);
        check("done_seen", {63'b0, done_of(sel)}, 64'd1);
        check("done_latency", 64'(cyc - last_cyc), (sel == 0) ? 64'(N + 2) : 64'd0);
        check("end_busy", {63'b0, busy_of(sel)}, 64'd0);
        check("end_hold", {63'b0, hold_of(sel)}, 64'd0);
        check("checksum", 64'(cks_of(sel)), 64'(exp_sum));
        check("error", {63'b0, err_of(sel)}, {63'b0, corrupt && sel == 0});
        if (sel == 1) check("no_read_phase", 64'(nonwrite_busy_b - nonw0), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("done_pulses", 64'((sel == 0 ? rise_a : rise_b) - rises0), 64'd1);
        check("done_sticky", {63'b0, done_of(sel)}, 64'd1);
        check("idle_after", {63'b0, busy_of(sel)}, 64'd0);
        check("sb_empty", 64'(sel == 0 ? exp_a.size() : exp_b.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'b0, busy_a}, 64'd0);
        check("reset_hold", {63'b0, hold_a}, 64'd0);
        check("reset_ready", {63'b0, bus_a.s_ready}, 64'd0);
        check("reset_wen", {63'b0, bus_a.mem_wen}, 64'd0);
        check("reset_addr", 64'(bus_a.mem_addr), 64'd0);
        check("reset_din", 64'(bus_a.mem_din), 64'd0);
        check("reset_done", {63'b0, done_a}, 64'd0);
        check("reset_error", {63'b0, err_a}, 64'd0);
        check("reset_cks", 64'(cks_a), 64'd0);
        check("reset_b_busy", {63'b0, busy_b}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {63'b0, bus_a.s_ready}, 64'd0);
        check("idle_done", {63'b0, done_a}, 64'd0);

        for (int i = 0; i < N; i++) words[i] = WS'(i + 1);
        run_load(0, 0, 0, 1'b0, 1'b0);
        run_load(0, 1, 0, 1'b0, 1'b0);
        run_load(0, 0, 0, 1'b0, 1'b1);
        run_load(1, 0, 0, 1'b0, 1'b0);
        run_load(0, 0, 3, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) words[i] = $urandom;
        run_load(0, 2, 0, 1'b0, 1'b0);
        run_load(0, 0, 0, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) words[i] = $urandom;
            run_load(r % 2, 2, 0, r == 2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
